tron_move_ctrl: RTL and testbench

//  Per-frame movement sequencer for the two-player Tron game. Sits between the
//  two keyboard direction decoders and the shared pixel plotter.

---
 rtl/tron_move_ctrl.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_tron_move_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tron_move_ctrl.sv
// tron_move_ctrl
//   Per-frame movement sequencer for the two-player Tron game. Buffers each
//   player's turn requests in a 2-entry FIFO, applies at most one turn per
//   player per game tick (reversals and no-op turns are dropped), advances both
//   heads, then shares the single pixel-plotter port between the players with
//   a req/ack handshake. The player drawn first alternates every frame.
//
// Configuration macro: TRON_WRAP_EN
//   defined   : heads wrap to the opposite edge; crash_a/crash_b stay 0.
//   undefined : a step off the playfield leaves the head in place, sets the
//               player's sticky crash flag and freezes that player.
//
// Ports
//   clk, reset        system clock; asynchronous active-high reset
//   tick              one-clk game-step pulse
//   dir_a, dir_b      one-hot direction UP=10000 DN=01000 LT=00100 RT=00010
//   draw_ack          plotter accepted the current pixel
//   draw_req          pixel write request (coords stable while high)
//   draw_x, draw_y    pixel coordinates
//   draw_player       0 = player A colour, 1 = player B colour
//   head_a_x/y        player A head position
//   head_b_x/y        player B head position
//   crash_a, crash_b  sticky edge-crash flags
//   busy              sequencer not idle
//   overrun           one-clk pulse: tick dropped because a frame was running
module tron_move_ctrl #(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119,
    parameter int A_X0  = 20,
    parameter int A_Y0  = 60,
    parameter int B_X0  = 139,
    parameter int B_Y0  = 60
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic [4:0]     dir_a,
    input  logic [4:0]     dir_b,
    input  logic           draw_ack,
    output logic           draw_req,
    output logic [X_W-1:0] draw_x,
    output logic [Y_W-1:0] draw_y,
    output logic           draw_player,
    output logic [X_W-1:0] head_a_x,
    output logic [Y_W-1:0] head_a_y,
    output logic [X_W-1:0] head_b_x,
    output logic [Y_W-1:0] head_b_y,
    output logic           crash_a,
    output logic           crash_b,
    output logic           busy,
    output logic           overrun
);

    typedef enum logic [1:0] {UP = 2'd0, DN = 2'd1, LT = 2'd2, RT = 2'd3} dir_t;
    typedef enum logic [2:0] {IDLE, STEER, MOVE, DRAW1, DRAW2} state_t;

    // e0 is the oldest entry; a push into a full FIFO replaces e1.
    typedef struct packed {
        dir_t       e0;
        dir_t       e1;
        logic [1:0] cnt;
    } fifo_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           hit;
    } step_t;

    function automatic logic dir_valid(input logic [4:0] v);
        return (v == 5'b10000) || (v == 5'b01000) || (v == 5'b00100) || (v == 5'b00010);
    endfunction

    function automatic dir_t dir_decode(input logic [4:0] v);
        dir_t d;
        case (v)
            5'b10000: d = UP;
            5'b01000: d = DN;
            5'b00100: d = LT;
            default:  d = RT;
        endcase
        return d;
    endfunction

    function automatic dir_t dir_reverse(input dir_t d);
        dir_t r;
        case (d)
            UP:      r = DN;
            DN:      r = UP;
            LT:      r = RT;
            default: r = LT;
        endcase
        return r;
    endfunction

    // Pop is applied before push, so a push in the same cycle as a pop on a
    // full FIFO lands in the freed slot instead of overwriting.
    function automatic fifo_t fifo_next(input fifo_t f, input logic pop, input logic push,
                                        input dir_t d);
        fifo_t r;
        r = f;
        if (pop && (r.cnt != 2'd0)) begin
            r.e0  = r.e1;
            r.cnt = r.cnt - 2'd1;
        end
        if (push) begin
            case (r.cnt)
                2'd0:    begin r.e0 = d; r.cnt = 2'd1; end
                2'd1:    begin r.e1 = d; r.cnt = 2'd2; end
                default: r.e1 = d;
            endcase
        end
        return r;
    endfunction

    // A frozen (crashed) player still drains its FIFO but never turns.
    function automatic dir_t steer(input dir_t h, input fifo_t f, input logic frozen);
        dir_t r;
        r = h;
        if ((f.cnt != 2'd0) && !frozen && (f.e0 != h) && (f.e0 != dir_reverse(h)))
            r = f.e0;
        return r;
    endfunction

    function automatic step_t advance_head(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                           input dir_t h);
        step_t r;
        r.x   = x;
        r.y   = y;
        r.hit = 1'b0;
        case (h)
            UP: if (y == '0) begin
`ifdef TRON_WRAP_EN
                    r.y = Y_W'(Y_MAX);
`else
                    r.hit = 1'b1;
`endif
                end else r.y = y - Y_W'(1);
            DN: if (y == Y_W'(Y_MAX)) begin
`ifdef TRON_WRAP_EN
                    r.y = '0;
`else
                    r.hit = 1'b1;
`endif
                end else r.y = y + Y_W'(1);
            LT: if (x == '0) begin
`ifdef TRON_WRAP_EN
                    r.x = X_W'(X_MAX);
`else
                    r.hit = 1'b1;
`endif
                end else r.x = x - X_W'(1);
            default: if (x == X_W'(X_MAX)) begin
`ifdef TRON_WRAP_EN
                    r.x = '0;
`else
                    r.hit = 1'b1;
`endif
                end else r.x = x + X_W'(1);
        endcase
        return r;
    endfunction

    state_t         state;
    dir_t           hdir_a, hdir_b;
    dir_t           last_a, last_b;
    fifo_t          fifo_a, fifo_b;
    fifo_t          fifo_a_nxt, fifo_b_nxt;
    step_t          mv_a, mv_b;
    logic           b_first;
    logic           push_a, push_b, pop;
    logic           first_dead;
    logic           cur_p, cur_crash, draw_done;
    logic [X_W-1:0] cur_x;
    logic [Y_W-1:0] cur_y;

    // NOTE: every signal gets a value on every path through this block, so no latches are inferred.
    always_comb begin
        pop        = (state == STEER);
        push_a     = dir_valid(dir_a) && (dir_decode(dir_a) != last_a);
        push_b     = dir_valid(dir_b) && (dir_decode(dir_b) != last_b);
        fifo_a_nxt = fifo_next(fifo_a, pop, push_a, dir_decode(dir_a));
        fifo_b_nxt = fifo_next(fifo_b, pop, push_b, dir_decode(dir_b));
        mv_a       = advance_head(head_a_x, head_a_y, hdir_a);
        mv_b       = advance_head(head_b_x, head_b_y, hdir_b);
        // The first player's draw is decided on the MOVE edge, so look at the
        // crash state that edge is about to produce.
        first_dead = b_first ? (crash_b | mv_b.hit) : (crash_a | mv_a.hit);
        cur_p      = (state == DRAW1) ? b_first : ~b_first;
        cur_crash  = cur_p ? crash_b : crash_a;
        cur_x      = cur_p ? head_b_x : head_a_x;
        cur_y      = cur_p ? head_b_y : head_a_y;
        // A draw slot ends on ack, or immediately for a crashed player.
        draw_done  = draw_req ? draw_ack : cur_crash;
    end

    assign busy = (state != IDLE);

    // NOTE: non-blocking assignments keep every register update in this block
    // sampling pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            hdir_a      <= RT;
            hdir_b      <= LT;
            last_a      <= RT;
            last_b      <= LT;
            // NOTE: the FIFO storage is a handful of flops, so it is reset
            // with everything else rather than left uninitialised like a RAM.
            fifo_a      <= '0;
            fifo_b      <= '0;
            head_a_x    <= X_W'(A_X0);
            head_a_y    <= Y_W'(A_Y0);
            head_b_x    <= X_W'(B_X0);
            head_b_y    <= Y_W'(B_Y0);
            crash_a     <= 1'b0;
            crash_b     <= 1'b0;
            draw_req    <= 1'b0;
            draw_x      <= '0;
            draw_y      <= '0;
            draw_player <= 1'b0;
            overrun     <= 1'b0;
            b_first     <= 1'b0;
        end else begin
            fifo_a  <= fifo_a_nxt;
            fifo_b  <= fifo_b_nxt;
            if (dir_valid(dir_a)) last_a <= dir_decode(dir_a);
            if (dir_valid(dir_b)) last_b <= dir_decode(dir_b);
            overrun <= tick && (state != IDLE);

            case (state)
                IDLE: if (tick) state <= STEER;
                STEER: begin
                    hdir_a <= steer(hdir_a, fifo_a, crash_a);
                    hdir_b <= steer(hdir_b, fifo_b, crash_b);
                    state  <= MOVE;
                end
                MOVE: begin
                    if (!crash_a) begin
                        head_a_x <= mv_a.x;
                        head_a_y <= mv_a.y;
                        crash_a  <= mv_a.hit;
                    end
                    if (!crash_b) begin
                        head_b_x <= mv_b.x;
                        head_b_y <= mv_b.y;
                        crash_b  <= mv_b.hit;
                    end
                    // Raise the first request straight from the new head
                    // position so it is visible on the first DRAW1 cycle.
                    if (!first_dead) begin
                        draw_req    <= 1'b1;
                        draw_player <= b_first;
                        draw_x      <= b_first ? mv_b.x : mv_a.x;
                        draw_y      <= b_first ? mv_b.y : mv_a.y;
                    end
                    state <= DRAW1;
                end
                DRAW1, DRAW2: begin
                    if (draw_done) begin
                        draw_req <= 1'b0;
                        if (state == DRAW1) begin
                            state <= DRAW2;
                        end else begin
                            state   <= IDLE;
                            b_first <= ~b_first;
                        end
                    end else if (!draw_req) begin
                        // Entering DRAW2 after an ack: req stays low one clk first.
                        draw_req    <= 1'b1;
                        draw_player <= cur_p;
                        draw_x      <= cur_x;
                        draw_y      <= cur_y;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tron_move_ctrl.sv
// tb_tron_move_ctrl
//   Directed bench for tron_move_ctrl: reset state, first-frame latency and
//   draw order, reversal rejection, FIFO tail overwrite, overrun while the
//   plotter stalls, edge crash / wrap, and reset during a handshake.
module tb_tron_move_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [4:0] dir_a, dir_b;
    logic       draw_ack;
    logic       draw_req;
    logic [7:0] draw_x;
    logic [6:0] draw_y;
    logic       draw_player;
    logic [7:0] head_a_x, head_b_x;
    logic [6:0] head_a_y, head_b_y;
    logic       crash_a, crash_b, busy, overrun;

    int tests = 0;
    int fails = 0;

    localparam logic [4:0] D_UP = 5'b10000;
    localparam logic [4:0] D_DN = 5'b01000;
    localparam logic [4:0] D_LT = 5'b00100;

    tron_move_ctrl dut (
        .clk(clk), .reset(reset), .tick(tick), .dir_a(dir_a), .dir_b(dir_b),
        .draw_ack(draw_ack), .draw_req(draw_req), .draw_x(draw_x), .draw_y(draw_y),
        .draw_player(draw_player), .head_a_x(head_a_x), .head_a_y(head_a_y),
        .head_b_x(head_b_x), .head_b_y(head_b_y), .crash_a(crash_a), .crash_b(crash_b),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in STEER (tick sampled on the edge inside this task).
    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic expect_draw(input string tag, input logic p, input int x, input int y,
                               input int hold);
        int n = 0;
        while (!draw_req && n < 20) begin
            step();
            n++;
        end
        check({tag, "_req"}, 32'(draw_req), 1);
        check({tag, "_player"}, 32'(draw_player), 32'(p));
        check({tag, "_x"}, 32'(draw_x), x);
        check({tag, "_y"}, 32'(draw_y), y);
        repeat (hold) step();
        draw_ack = 1'b1;
        step();
        draw_ack = 1'b0;
        check({tag, "_drop"}, 32'(draw_req), 0);
    endtask

    task automatic quick_frame();
        int n = 0;
        pulse_tick();
        while (busy && n < 40) begin
            draw_ack = draw_req;
            step();
            n++;
        end
        draw_ack = 1'b0;
        check("quick_idle", 32'(busy), 0);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; dir_a = '0; dir_b = '0; draw_ack = 1'b0;
        repeat (2) step();
        reset = 1'b0;
        step();

        // Reset state
        check("rst_ax", 32'(head_a_x), 20);
        check("rst_ay", 32'(head_a_y), 60);
        check("rst_bx", 32'(head_b_x), 139);
        check("rst_by", 32'(head_b_y), 60);
        check("rst_req", 32'(draw_req), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_crash", 32'({crash_a, crash_b}), 0);
        check("rst_dxy", 32'({draw_x, draw_y}), 0);

        // Frame 1: A first, request three cycles after the tick cycle
        pulse_tick();
        check("f1_busy", 32'(busy), 1);
        step();
        step();
        check("f1_latency", 32'(draw_req), 1);
        expect_draw("f1_a", 1'b0, 21, 60, 1);
        expect_draw("f1_b", 1'b1, 138, 60, 1);
        check("f1_idle", 32'(busy), 0);

        // Frame 2: reversal LT while heading RT is discarded; B draws first
        dir_a = D_LT;
        step();
        dir_a = 5'b00000;
        step();
        pulse_tick();
        expect_draw("f2_b", 1'b1, 137, 60, 0);
        expect_draw("f2_a", 1'b0, 22, 60, 0);

        // Frames 3/4: UP, DN, LT queued; LT overwrites DN in the full FIFO
        dir_a = D_UP; step();
        dir_a = D_DN; step();
        dir_a = D_LT; step();
        dir_a = 5'b00000; step();
        pulse_tick();
        expect_draw("f3_a", 1'b0, 22, 59, 0);
        expect_draw("f3_b", 1'b1, 136, 60, 0);
        pulse_tick();
        expect_draw("f4_b", 1'b1, 135, 60, 0);
        expect_draw("f4_a", 1'b0, 21, 59, 0);

        // Frame 5: plotter stalls 10 clk, a tick mid-frame pulses overrun once
        pulse_tick();
        step();
        step();
        check("f5_req", 32'(draw_req), 1);
        check("f5_x", 32'(draw_x), 20);
        step(); step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("f5_ovr_hi", 32'(overrun), 1);
        step();
        check("f5_ovr_lo", 32'(overrun), 0);
        repeat (6) step();
        check("f5_hold_req", 32'(draw_req), 1);
        check("f5_hold_x", 32'(draw_x), 20);
        check("f5_hold_y", 32'(draw_y), 59);
        draw_ack = 1'b1;
        step();
        draw_ack = 1'b0;
        check("f5_drop", 32'(draw_req), 0);
        expect_draw("f5_b", 1'b1, 134, 60, 0);
        repeat (5) step();
        check("f5_no_extra", 32'(busy), 0);
        check("f5_ax_kept", 32'(head_a_x), 20);

        // Frame 6: reset during a handshake drops draw_req at once
        pulse_tick();
        step();
        step();
        check("f6_req", 32'(draw_req), 1);
        check("f6_player", 32'(draw_player), 1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_req", 32'(draw_req), 0);
        check("rst_mid_ax", 32'(head_a_x), 20);
        check("rst_mid_ay", 32'(head_a_y), 60);
        check("rst_mid_bx", 32'(head_b_x), 139);
        step();
        reset = 1'b0;
        step();

        // Drive both heads to opposite edges: A to x=159, B to x=0
        for (int i = 0; i < 139; i++) quick_frame();
        check("edge_ax", 32'(head_a_x), 159);
        check("edge_bx", 32'(head_b_x), 0);
        check("edge_crash", 32'({crash_a, crash_b}), 0);

`ifdef TRON_WRAP_EN
        pulse_tick();
        expect_draw("wrap_b", 1'b1, 159, 60, 0);
        expect_draw("wrap_a", 1'b0, 0, 60, 0);
        check("wrap_crash", 32'({crash_a, crash_b}), 0);
        pulse_tick();
        expect_draw("wrap2_a", 1'b0, 1, 60, 0);
        expect_draw("wrap2_b", 1'b1, 158, 60, 0);
`else
        pulse_tick();
        step();
        step();
        check("crash_d1_req", 32'(draw_req), 0);
        step();
        check("crash_d2_req", 32'(draw_req), 0);
        step();
        check("crash_idle", 32'(busy), 0);
        check("crash_a", 32'(crash_a), 1);
        check("crash_b", 32'(crash_b), 1);
        check("crash_ax", 32'(head_a_x), 159);
        check("crash_bx", 32'(head_b_x), 0);

        // Frozen player ignores a queued turn; nothing is drawn
        dir_a = D_UP;
        step();
        dir_a = 5'b00000;
        pulse_tick();
        step();
        step();
        check("frozen_req", 32'(draw_req), 0);
        step();
        step();
        check("frozen_idle", 32'(busy), 0);
        check("frozen_ax", 32'(head_a_x), 159);
        check("frozen_ay", 32'(head_a_y), 60);
        check("frozen_crash", 32'(crash_a), 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
